// File: rtl/alarm_zoned.sv
// Multi-zone alarm panel: instant/delayed zones, entry delay, optional siren timeout, sticky trip record.
// Outputs are registered Moore decodes of state; ready is combinational. Exit delay option: ALARM_EXIT_DELAY_EN.
module alarm_zoned #(
    parameter int                NUM_ZONES     = 3,
    parameter int                CODE_W        = 4,
    parameter logic [CODE_W-1:0] ARM_CODE      = 4'b0011,
    parameter logic [CODE_W-1:0] DISARM_CODE   = 4'b1100,
    parameter int                ENTRY_DELAY   = 100,
    parameter int                SIREN_TIMEOUT = 0,
    parameter int                EXIT_DELAY    = 60,
    parameter int                CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_ZONES-1:0] zones,
    input  logic [NUM_ZONES-1:0] instant_mask,
    input  logic [CODE_W-1:0]    keypad,
    output logic                 alarm_siren,
    output logic                 is_armed,
    output logic                 is_wait_delay,
    output logic                 ready,
    output logic [NUM_ZONES-1:0] fault_latch,
    output logic [CNT_W-1:0]     delay_remaining
);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_ARMED    = 3'd1,
        S_WAIT     = 3'd2,
        S_SIREN    = 3'd3
`ifdef ALARM_EXIT_DELAY_EN
        , S_EXIT   = 3'd4
`endif
    } state_t;

    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = (SIREN_TIMEOUT > 0) ? CNT_W'(SIREN_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_ZONES-1:0]   r_fault_latch;
    logic                   r_siren;
    logic                   r_armed;
    logic                   r_wait;
    logic [CNT_W-1:0]       r_delay;

    state_t                 w_nxt_state;
    logic [CNT_W-1:0]       w_nxt_cnt;
    logic [NUM_ZONES-1:0]   w_nxt_latch;
    logic                   w_nxt_armed;
    logic                   w_arm;
    logic                   w_disarm;
    logic                   w_instant;
    logic                   w_any;

    assign ready     = ~|zones;
    assign w_arm     = (keypad == ARM_CODE);
    assign w_disarm  = (keypad == DISARM_CODE);
    assign w_instant = |(zones & instant_mask);
    assign w_any     = |zones;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_latch = r_fault_latch;
        case (r_state)
            S_DISARMED: begin
                if (w_arm && ready) begin
                    w_nxt_latch = '0;
                    // Counter is a don't-care in ARMED, so the exit preload is harmless without the option.
                    w_nxt_cnt   = EXIT_LOAD;
`ifdef ALARM_EXIT_DELAY_EN
                    w_nxt_state = S_EXIT;
`else
                    w_nxt_state = S_ARMED;
`endif
                end
            end
            S_ARMED: begin
                w_nxt_latch = r_fault_latch | zones;
                if (w_disarm) begin
                    w_nxt_state = S_DISARMED;
                    w_nxt_cnt   = '0;
                end else if (w_instant) begin
                    w_nxt_state = S_SIREN;
                    w_nxt_cnt   = SIREN_LOAD;
                end else if (w_any) begin
                    w_nxt_state = S_WAIT;
                    w_nxt_cnt   = ENTRY_LOAD;
                end
            end
            S_WAIT: begin
                w_nxt_latch = r_fault_latch | zones;
                if (w_disarm) begin
                    w_nxt_state = S_DISARMED;
                    w_nxt_cnt   = '0;
                end else if (w_instant || (r_cnt == '0)) begin
                    w_nxt_state = S_SIREN;
                    w_nxt_cnt   = SIREN_LOAD;
                end else begin
                    w_nxt_cnt   = r_cnt - CNT_W'(1);
                end
            end
            S_SIREN: begin
                w_nxt_latch = r_fault_latch | zones;
                if (w_disarm) begin
                    w_nxt_state = S_DISARMED;
                    w_nxt_cnt   = '0;
                end else if (SIREN_TIMEOUT > 0) begin
                    if (r_cnt == '0) begin
                        w_nxt_state = S_ARMED;
                    end else begin
                        w_nxt_cnt   = r_cnt - CNT_W'(1);
                    end
                end
            end
`ifdef ALARM_EXIT_DELAY_EN
            S_EXIT: begin
                // Zones are deliberately neither acted on nor latched while the occupant leaves.
                if (w_disarm) begin
                    w_nxt_state = S_DISARMED;
                    w_nxt_cnt   = '0;
                end else if (r_cnt == '0) begin
                    w_nxt_state = S_ARMED;
                end else begin
                    w_nxt_cnt   = r_cnt - CNT_W'(1);
                end
            end
`endif
            default: begin
                w_nxt_state = S_DISARMED;
                w_nxt_cnt   = '0;
            end
        endcase
`ifdef ALARM_EXIT_DELAY_EN
        w_nxt_armed = (w_nxt_state == S_ARMED) || (w_nxt_state == S_EXIT);
`else
        w_nxt_armed = (w_nxt_state == S_ARMED);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_DISARMED;
            r_cnt         <= '0;
            r_fault_latch <= '0;
            r_siren       <= 1'b0;
            r_armed       <= 1'b0;
            r_wait        <= 1'b0;
            r_delay       <= '0;
        end else begin
            r_state       <= w_nxt_state;
            r_cnt         <= w_nxt_cnt;
            r_fault_latch <= w_nxt_latch;
            r_siren       <= (w_nxt_state == S_SIREN);
            r_armed       <= w_nxt_armed;
            r_wait        <= (w_nxt_state == S_WAIT);
            r_delay       <= (w_nxt_state == S_WAIT) ? w_nxt_cnt : '0;
        end
    end

    assign alarm_siren     = r_siren;
    assign is_armed        = r_armed;
    assign is_wait_delay   = r_wait;
    assign fault_latch     = r_fault_latch;
    assign delay_remaining = r_delay;

endmodule

// File: tb/tb_alarm_zoned.sv
// Bench for alarm_zoned: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a timestamp-based model of the panel.
module tb_alarm_zoned;

    localparam int        NZ   = 3;
    localparam int        CW   = 4;
    localparam int        ED   = 100;
    localparam int        ST   = 20;
    localparam int        XD   = 8;
    localparam int        CNTW = 16;
    localparam logic [CW-1:0] ARM = 4'b0011;
    localparam logic [CW-1:0] DIS = 4'b1100;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NZ-1:0]   zones = '0;
    logic [NZ-1:0]   instant_mask = '0;
    logic [CW-1:0]   keypad = '0;
    logic            alarm_siren;
    logic            is_armed;
    logic            is_wait_delay;
    logic            ready;
    logic [NZ-1:0]   fault_latch;
    logic [CNTW-1:0] delay_remaining;

    always #5 clk = ~clk;

    alarm_zoned #(
        .NUM_ZONES    (NZ),
        .CODE_W       (CW),
        .ARM_CODE     (ARM),
        .DISARM_CODE  (DIS),
        .ENTRY_DELAY  (ED),
        .SIREN_TIMEOUT(ST),
        .EXIT_DELAY   (XD),
        .CNT_W        (CNTW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .zones          (zones),
        .instant_mask   (instant_mask),
        .keypad         (keypad),
        .alarm_siren    (alarm_siren),
        .is_armed       (is_armed),
        .is_wait_delay  (is_wait_delay),
        .ready          (ready),
        .fault_latch    (fault_latch),
        .delay_remaining(delay_remaining)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] st();
        return {29'd0, is_armed, is_wait_delay, alarm_siren};
    endfunction

    // Model: mode plus absolute edge-number deadlines instead of down-counters.
    typedef enum int {M_DIS, M_ARM, M_WAIT, M_SIREN, M_EXIT} mmode_t;
    mmode_t        m_mode = M_DIS;
    int            m_cyc = 0;
    int            m_wait_end = 0;
    int            m_siren_end = 0;
    int            m_exit_end = 0;
    logic [NZ-1:0] m_latch = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode  = M_DIS;
            m_latch = '0;
            m_cyc   = 0;
        end else begin
            m_cyc++;
            if (m_mode == M_ARM || m_mode == M_WAIT || m_mode == M_SIREN)
                m_latch = m_latch | zones;
            if (m_mode != M_DIS && keypad == DIS) begin
                m_mode = M_DIS;
            end else begin
                case (m_mode)
                    M_DIS: if (keypad == ARM && zones == '0) begin
                        m_latch = '0;
`ifdef ALARM_EXIT_DELAY_EN
                        m_mode     = M_EXIT;
                        m_exit_end = m_cyc + XD;
`else
                        m_mode = M_ARM;
`endif
                    end
                    M_EXIT: if (m_cyc == m_exit_end) m_mode = M_ARM;
                    M_ARM, M_WAIT: begin
                        if ((|(zones & instant_mask)) || (m_mode == M_WAIT && m_cyc == m_wait_end)) begin
                            m_mode      = M_SIREN;
                            m_siren_end = m_cyc + ST;
                        end else if (m_mode == M_ARM && (|zones)) begin
                            m_mode     = M_WAIT;
                            m_wait_end = m_cyc + ED;
                        end
                    end
                    M_SIREN: if (ST > 0 && m_cyc == m_siren_end) m_mode = M_ARM;
                    default: m_mode = M_DIS;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] exp_st;
        logic [31:0] exp_dr;
        exp_st = {29'd0, (m_mode == M_ARM || m_mode == M_EXIT), (m_mode == M_WAIT), (m_mode == M_SIREN)};
        exp_dr = (m_mode == M_WAIT) ? 32'(m_wait_end - m_cyc - 1) : 32'd0;
        chk("model_status", st(), exp_st);
        chk("model_latch", 32'(fault_latch), 32'(m_latch));
        chk("model_delay", 32'(delay_remaining), exp_dr);
        chk("model_ready", 32'(ready), 32'(~|zones));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm();
        keypad = ARM;
        step(1);
        keypad = '0;
`ifdef ALARM_EXIT_DELAY_EN
        step(XD);
`endif
    endtask

    task automatic disarm();
        keypad = DIS;
        step(1);
        keypad = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, n_chk %0d", n_chk);
        $fatal(1);
    end

    initial begin
        int r;
        #1 reset = 1'b0;
        step(10);
        reset = 1'b1;
        step(11);
        chk("t1_status", st(), 32'b000);
        chk("t1_latch", 32'(fault_latch), 32'd0);

        arm();
        step(10);
        chk("t2_armed", st(), 32'b100);
        disarm();
        chk("t2_disarm", st(), 32'b000);

        arm();
        zones = 3'b001;
        step(1);
        zones = '0;
        chk("t3_wait", st(), 32'b010);
        chk("t3_delay99", 32'(delay_remaining), 32'd99);
        step(50);
        chk("t3_wait50", st(), 32'b010);
        chk("t3_delay49", 32'(delay_remaining), 32'd49);
        disarm();
        chk("t3_disarm", st(), 32'b000);
        chk("t3_latch", 32'(fault_latch), 32'b001);

        arm();
        chk("t4_latch_clr", 32'(fault_latch), 32'd0);
        zones = 3'b010;
        step(1);
        zones = '0;
        step(99);
        chk("t4_wait_end", st(), 32'b010);
        chk("t4_delay0", 32'(delay_remaining), 32'd0);
        step(1);
        chk("t4_siren", st(), 32'b001);
        step(19);
        chk("t4_siren20", st(), 32'b001);
        step(1);
        chk("t4_timeout", st(), 32'b100);
        chk("t4_latch_kept", 32'(fault_latch), 32'b010);
        disarm();
        chk("t4_disarm", st(), 32'b000);

        instant_mask = 3'b100;
        arm();
        zones = 3'b100;
        step(1);
        zones = '0;
        chk("t5_instant", st(), 32'b001);
        disarm();
        chk("t5_disarm", st(), 32'b000);
        chk("t5_latch", 32'(fault_latch), 32'b100);
        zones = 3'b001;
        #1;
        chk("t5_not_ready", 32'(ready), 32'd0);
        keypad = ARM;
        step(1);
        keypad = '0;
        step(2);
        chk("t5_refused", st(), 32'b000);
        zones = '0;
        step(1);
        chk("t5_ready", 32'(ready), 32'd1);

`ifdef ALARM_EXIT_DELAY_EN
        keypad = ARM;
        step(1);
        keypad = '0;
        chk("t6_exit", st(), 32'b100);
        zones = 3'b111;
        step(XD - 1);
        chk("t6_exit_ignore", st(), 32'b100);
        chk("t6_exit_nolatch", 32'(fault_latch), 32'd0);
        zones = '0;
        step(1);
        chk("t6_armed", st(), 32'b100);
        disarm();
`endif

        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10)       keypad = ARM;
            else if (r == 10) keypad = DIS;
            else              keypad = CW'($urandom);
            r = $urandom_range(0, 99);
            zones = (r < 8) ? NZ'($urandom) : '0;
            if ($urandom_range(0, 199) == 0) instant_mask = NZ'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                step(1);
                reset = 1'b1;
            end else begin
                step(1);
            end
        end
        zones  = '0;
        keypad = '0;
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
